// File: rtl/codec_intf_pkg.sv
// Shared constants, bus payload and warm-up state type for the codec serial interface.
package codec_intf_pkg;

    localparam int unsigned SMPL_W = 16;
    localparam int unsigned CNT_W  = 10;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned NIB_W  = 4;

    // Counter values at which the receive side captures and flags a stereo pair
    localparam logic [CNT_W-1:0] RX_CAP_L  = 10'h107;
    localparam logic [CNT_W-1:0] RX_CAP_R  = 10'h307;
    localparam logic [CNT_W-1:0] VALID_CNT = 10'h308;

    // Low nibble of the counter marking SCLK rise / fall events
    localparam logic [NIB_W-1:0] RISE_NIB = 4'h7;
    localparam logic [NIB_W-1:0] FALL_NIB = 4'hF;

    // Data bits occupy half-frame indices 1..16 (one-bit I2S delay)
    localparam logic [IDX_W-1:0] IDX_FIRST = 5'd1;
    localparam logic [IDX_W-1:0] IDX_LAST  = 5'd16;

    typedef struct packed {
        logic [SMPL_W-1:0] lft;
        logic [SMPL_W-1:0] rht;
    } stereo_t;

    // Bit 0 drives the codec RSTn pin, bit 1 releases the valid strobe
    typedef enum logic [1:0] {
        WARM_CODEC_RST = 2'b00,
        WARM_MUTE      = 2'b01,
        WARM_RUN       = 2'b11
    } warm_state_e;

    function automatic logic is_data_idx(input logic [IDX_W-1:0] idx);
        return (idx >= IDX_FIRST) && (idx <= IDX_LAST);
    endfunction

endpackage

// File: rtl/codec_clk_gen.sv
// Frame counter, codec clocks, codec reset and warm-up sequencing, plus the
// bit-event decodes used by the serial datapath.
module codec_clk_gen
    import codec_intf_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_LRCLK,
    output logic             o_SCLK,
    output logic             o_MCLK,
    output logic             o_RSTn,
    output logic             o_warm_done,
    output logic [IDX_W-1:0] o_idx_c,
    output logic             o_rise_c,
    output logic             o_fall_c
);

    logic [CNT_W-1:0] r_cnt;
    warm_state_e      r_state;
    warm_state_e      w_state_nxt;
    logic             w_wrap;

    // Free-running frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_wrap = (r_cnt == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WARM_CODEC_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Codec held in reset for one frame, then one muted frame before valid is released
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WARM_CODEC_RST: if (w_wrap) w_state_nxt = WARM_MUTE;
            WARM_MUTE:      if (w_wrap) w_state_nxt = WARM_RUN;
            WARM_RUN:       w_state_nxt = WARM_RUN;
            default:        w_state_nxt = WARM_CODEC_RST;
        endcase
    end

    assign o_cnt       = r_cnt;
    assign o_LRCLK     = r_cnt[9];
    assign o_SCLK      = r_cnt[3];
    assign o_MCLK      = r_cnt[1];
    assign o_RSTn      = r_state[0];
    assign o_warm_done = r_state[1];

    assign o_idx_c  = r_cnt[CNT_W-2:NIB_W];
    assign o_rise_c = (r_cnt[NIB_W-1:0] == RISE_NIB);
    assign o_fall_c = (r_cnt[NIB_W-1:0] == FALL_NIB);

endmodule

// File: rtl/codec_intf.sv
// I2S-style stereo codec interface: serial receive into lft_out/rht_out with a
// valid strobe, serial transmit of lft_in/rht_in. Define CODEC_LOOPBACK_EN to
// transmit the received samples instead (ADC->DAC loopback).
module codec_intf
    import codec_intf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SMPL_W-1:0] lft_in,
    input  logic [SMPL_W-1:0] rht_in,
    input  logic              SDin,
    output logic [SMPL_W-1:0] lft_out,
    output logic [SMPL_W-1:0] rht_out,
    output logic              valid,
    output logic              LRCLK,
    output logic              SCLK,
    output logic              MCLK,
    output logic              SDout,
    output logic              RSTn
);

    logic [CNT_W-1:0]  w_cnt;
    logic [IDX_W-1:0]  w_idx;
    logic              w_rise;
    logic              w_fall;
    logic              w_warm_done;
    logic              w_data_idx;

    logic [SMPL_W-1:0] r_rx_sh;
    logic [SMPL_W-1:0] w_rx_nxt;
    stereo_t           r_out;
    logic              r_valid;

    stereo_t           w_tx_src;
    logic [SMPL_W-1:0] r_tx_sh;
    logic [SMPL_W-1:0] w_tx_nxt;
    logic              r_sdout;
    logic              w_sdout_nxt;

    codec_clk_gen u_clk_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .o_cnt       (w_cnt),
        .o_LRCLK     (LRCLK),
        .o_SCLK      (SCLK),
        .o_MCLK      (MCLK),
        .o_RSTn      (RSTn),
        .o_warm_done (w_warm_done),
        .o_idx_c     (w_idx),
        .o_rise_c    (w_rise),
        .o_fall_c    (w_fall)
    );

    assign w_data_idx = is_data_idx(w_idx);
    assign w_rx_nxt   = {r_rx_sh[SMPL_W-2:0], SDin};

    // Receive: shift MSB-first on data-bit rise events, capture at index 16
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_sh <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_rise && w_data_idx) begin
                r_rx_sh <= w_rx_nxt;
            end
            if (w_cnt == RX_CAP_L) begin
                r_out.lft <= w_rx_nxt;
            end
            if (w_cnt == RX_CAP_R) begin
                r_out.rht <= w_rx_nxt;
            end
            r_valid <= (w_cnt == VALID_CNT - CNT_W'(1)) && w_warm_done;
        end
    end

`ifdef CODEC_LOOPBACK_EN
    logic w_unused_tx_in;
    assign w_tx_src       = r_out;
    assign w_unused_tx_in = ^{lft_in, rht_in};
`else
    assign w_tx_src = '{lft: lft_in, rht: rht_in};
`endif

    // Transmit: load at index 0 fall, shift through index 15; SDout follows the MSB for 1..16
    always_comb begin
        w_tx_nxt    = r_tx_sh;
        w_sdout_nxt = r_sdout;
        if (w_fall) begin
            if (w_idx == '0) begin
                w_tx_nxt = w_cnt[CNT_W-1] ? w_tx_src.rht : w_tx_src.lft;
            end else if (w_idx < IDX_LAST) begin
                w_tx_nxt = {r_tx_sh[SMPL_W-2:0], 1'b0};
            end
            w_sdout_nxt = (w_idx < IDX_LAST) ? w_tx_nxt[SMPL_W-1] : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_sh <= '0;
            r_sdout <= 1'b0;
        end else begin
            r_tx_sh <= w_tx_nxt;
            r_sdout <= w_sdout_nxt;
        end
    end

    assign lft_out = r_out.lft;
    assign rht_out = r_out.rht;
    assign valid   = r_valid;
    assign SDout   = r_sdout;

endmodule

// File: tb/tb_codec_intf.sv
// Bench for codec_intf: cycle-accurate model derived from cycles-since-reset
// arithmetic, random and directed codec traffic, mid-frame reset.
`timescale 1ns/1ps
module tb_codec_intf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] lft_in = 16'h8001;
    logic [15:0] rht_in = 16'h7FFE;
    logic        SDin = 1'b0;
    logic [15:0] lft_out;
    logic [15:0] rht_out;
    logic        valid;
    logic        LRCLK;
    logic        SCLK;
    logic        MCLK;
    logic        SDout;
    logic        RSTn;

    codec_intf u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .lft_in  (lft_in),
        .rht_in  (rht_in),
        .SDin    (SDin),
        .lft_out (lft_out),
        .rht_out (rht_out),
        .valid   (valid),
        .LRCLK   (LRCLK),
        .SCLK    (SCLK),
        .MCLK    (MCLK),
        .SDout   (SDout),
        .RSTn    (RSTn)
    );

    always #10 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          t = 0;
    bit          after_mid = 1'b0;
    int          sd_mode = 0;
    int          tx_mode = 1;
    logic [15:0] sd_l = 16'h0;
    logic [15:0] sd_r = 16'h0;
    logic [15:0] exp_lft = 16'h0;
    logic [15:0] exp_rht = 16'h0;
    logic [15:0] cur_tx = 16'h0;
    logic [15:0] pat_l = 16'b1000000000000001;
    logic [15:0] pat_r = 16'b0111111111111110;
    logic [15:0] lb_l = 16'hA5C3;
    logic [15:0] lb_r = 16'h1234;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s t=%0d act=%b exp=%b", name, t, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s t=%0d act=%h exp=%h", name, t, act, exp);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk16({tag, "_lft_out"}, lft_out, 16'h0);
        chk16({tag, "_rht_out"}, rht_out, 16'h0);
        chk1({tag, "_valid"}, valid, 1'b0);
        chk1({tag, "_LRCLK"}, LRCLK, 1'b0);
        chk1({tag, "_SCLK"}, SCLK, 1'b0);
        chk1({tag, "_MCLK"}, MCLK, 1'b0);
        chk1({tag, "_SDout"}, SDout, 1'b0);
        chk1({tag, "_RSTn"}, RSTn, 1'b0);
    endtask

    // One clock cycle: compare outputs for cycle t, drive inputs, advance the model
    task automatic step();
        int   c;
        int   idx;
        int   half;
        int   f;
        bit   data;
        logic exp_sd;
        logic [15:0] word;
        c    = t % 1024;
        idx  = (c % 512) / 16;
        half = c / 512;
        f    = t / 1024;
        data = (idx >= 1) && (idx <= 16);

        chk1("LRCLK", LRCLK, c >= 512);
        chk1("SCLK", SCLK, (c % 16) >= 8);
        chk1("MCLK", MCLK, (c % 4) >= 2);
        chk1("RSTn", RSTn, t >= 1024);
        chk1("valid", valid, (c == 'h308) && (t >= 2048));
        chk16("lft_out", lft_out, exp_lft);
        chk16("rht_out", rht_out, exp_rht);
        exp_sd = data ? cur_tx[16 - idx] : 1'b0;
        chk1("SDout", SDout, exp_sd);

        if (t == 1023) chk1("lit_RSTn_low_at_3FF", RSTn, 1'b0);
        if (t == 1024) chk1("lit_RSTn_high_after_wrap", RSTn, 1'b1);
        if (sd_mode == 1 && c == 'h108) chk16("lit_lft_A5C3", lft_out, 16'hA5C3);
        if (sd_mode == 1 && c == 'h308) chk16("lit_rht_1234", rht_out, 16'h1234);
`ifndef CODEC_LOOPBACK_EN
        if (tx_mode == 1 && data) chk1("lit_sd_8001_7FFE", SDout, half != 0 ? pat_r[16 - idx] : pat_l[16 - idx]);
        if (tx_mode == 1 && !data) chk1("lit_sd_idle_zero", SDout, 1'b0);
        if (tx_mode == 2 && half == 0 && data) chk1("lit_sd_inflight_0000", SDout, 1'b0);
        if (tx_mode == 3 && half == 0 && data) chk1("lit_sd_next_FFFF", SDout, 1'b1);
`else
        if (!after_mid && f == 1 && data) chk1("lit_loopback", SDout, half != 0 ? lb_r[16 - idx] : lb_l[16 - idx]);
`endif

        // Per-frame stimulus plan
        if (c == 0) begin
            sd_mode = ((f == 0 || f == 1) && !after_mid) || (f == 0 && after_mid) ? 1 : 0;
            if (after_mid || f >= 4) tx_mode = 0;
            else if (f == 3) tx_mode = 3;
            else if (f == 2) tx_mode = 2;
            else tx_mode = 1;
            sd_l = (sd_mode == 1) ? 16'hA5C3 : 16'($urandom);
            sd_r = (sd_mode == 1) ? 16'h1234 : 16'($urandom);
            if (tx_mode == 1) begin
                lft_in = 16'h8001;
                rht_in = 16'h7FFE;
            end
            if (tx_mode == 2) lft_in = 16'h0000;
        end
        if (tx_mode == 2 && c == 'h080) lft_in = 16'hFFFF;
        if (tx_mode == 0) begin
            if ($urandom_range(0, 7) == 0) lft_in = 16'($urandom);
            if ($urandom_range(0, 7) == 0) rht_in = 16'($urandom);
        end
        word = (half != 0) ? sd_r : sd_l;
        SDin = data ? word[16 - idx] : 1'($urandom);

        // Model state visible from the next cycle
        if (c == 'h107) exp_lft = sd_l;
        if (c == 'h307) exp_rht = sd_r;
        if ((c % 512) == 'h00F) begin
`ifdef CODEC_LOOPBACK_EN
            cur_tx = (half != 0) ? exp_rht : exp_lft;
`else
            cur_tx = (half != 0) ? rht_in : lft_in;
`endif
        end
        t++;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_checks("por");
        rst_n = 1'b1;
        t = 0;
        while (t < 6 * 1024 + 'h150) step();

        rst_n = 1'b0;
        #1;
        reset_checks("mid");
        @(negedge clk);
        @(negedge clk);
        reset_checks("mid_hold");
        exp_lft = 16'h0;
        exp_rht = 16'h0;
        cur_tx = 16'h0;
        after_mid = 1'b1;
        t = 0;
        rst_n = 1'b1;
        while (t < 4 * 1024) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
